spi_master_ctrl: RTL and testbench

// - SPI master front end for the SPI-Master block: accepts a parallel word on a valid/ready handshake
//   and serialises it MSB-first on MOSI.
// - Generates SCLK (mode 0: CPOL=0, CPHA=0) and CS_n, and deserialises MISO into Rx_Data.
// - Owns the shift register and bit counter internally. Sits between the host-side word interface
//   and the SPI pins.

---
 rtl/spi_master_ctrl_if.sv | 25 ++
 rtl/spi_master_ctrl.sv | 140 ++++++++++++++
 tb/tb_spi_master_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_ctrl_if.sv
// Host-side word handshake plus SPI pin bundle for spi_master_ctrl.
// "slave" is the controller's view; "master" is the host/board side that drives it.
interface spi_master_ctrl_if #(
  parameter int Register_Width = 8
);
  logic [Register_Width-1:0] Tx_Data;
  logic                      Tx_Valid;
  logic                      Tx_Ready;
  logic [Register_Width-1:0] Rx_Data;
  logic                      Rx_Valid;
  logic                      SCLK;
  logic                      MOSI;
  logic                      MISO;
  logic                      CS_n;

  modport master (
    output Tx_Data, Tx_Valid, MISO,
    input  Tx_Ready, Rx_Data, Rx_Valid, SCLK, MOSI, CS_n
  );

  modport slave (
    input  Tx_Data, Tx_Valid, MISO,
    output Tx_Ready, Rx_Data, Rx_Valid, SCLK, MOSI, CS_n
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: accepts a word on valid/ready, shifts it out MSB-first on MOSI
// while capturing MISO, then reports the received word with a one-cycle Rx_Valid.
module spi_master_ctrl #(
  parameter int Register_Width = 8,
  parameter int CLK_DIV        = 4
) (
  input  logic              clk,
  input  logic              rst,
  spi_master_ctrl_if.slave  bus
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int BIT_W = $clog2(Register_Width);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(Register_Width - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t                    state_reg,    state_next;
  logic [DIV_W-1:0]          div_cnt_reg,  div_cnt_next;
  logic [BIT_W-1:0]          bit_cnt_reg,  bit_cnt_next;
  logic [Register_Width-1:0] shift_reg,    shift_next;
  logic [Register_Width-1:0] rx_data_reg,  rx_data_next;
  logic                      rx_valid_reg, rx_valid_next;
  logic                      sclk_reg,     sclk_next;
  logic                      mosi_reg,     mosi_next;
  logic                      cs_n_reg,     cs_n_next;
  logic                      tx_ready_reg, tx_ready_next;
  logic                      div_last;

  assign div_last = (div_cnt_reg == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      div_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      sclk_reg     <= 1'b0;
      mosi_reg     <= 1'b0;
      cs_n_reg     <= 1'b1;
      tx_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      div_cnt_reg  <= div_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      sclk_reg     <= sclk_next;
      mosi_reg     <= mosi_next;
      cs_n_reg     <= cs_n_next;
      tx_ready_reg <= tx_ready_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    div_cnt_next  = div_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    sclk_next     = sclk_reg;
    mosi_next     = mosi_reg;
    cs_n_next     = cs_n_reg;
    tx_ready_next = tx_ready_reg;

    case (state_reg)
      IDLE: begin
        if (bus.Tx_Valid && tx_ready_reg) begin
          state_next    = SETUP;
          shift_next    = bus.Tx_Data;
          mosi_next     = bus.Tx_Data[Register_Width-1];
          cs_n_next     = 1'b0;
          tx_ready_next = 1'b0;
          div_cnt_next  = '0;
          bit_cnt_next  = '0;
        end
      end

      SETUP: begin
        if (div_last) begin
          div_cnt_next = '0;
          state_next   = XFER;
        end else begin
          div_cnt_next = div_cnt_reg + DIV_W'(1);
        end
      end

      XFER: begin
        if (div_last) begin
          div_cnt_next = '0;
          if (!sclk_reg) begin
            // Capture and shift on the rising edge; MOSI is a separate register, so
            // the outgoing bit is already safe and the MISO bit can enter the LSB.
            sclk_next  = 1'b1;
            shift_next = {shift_reg[Register_Width-2:0], bus.MISO};
          end else begin
            sclk_next = 1'b0;
            if (bit_cnt_reg == BIT_LAST) begin
              state_next = HOLD;
            end else begin
              bit_cnt_next = bit_cnt_reg + BIT_W'(1);
              mosi_next    = shift_reg[Register_Width-1];
            end
          end
        end else begin
          div_cnt_next = div_cnt_reg + DIV_W'(1);
        end
      end

      HOLD: begin
        if (div_last) begin
          state_next    = IDLE;
          div_cnt_next  = '0;
          bit_cnt_next  = '0;
          rx_data_next  = shift_reg;
          rx_valid_next = 1'b1;
          cs_n_next     = 1'b1;
          tx_ready_next = 1'b1;
        end else begin
          div_cnt_next = div_cnt_reg + DIV_W'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.Tx_Ready = tx_ready_reg;
  assign bus.Rx_Data  = rx_data_reg;
  assign bus.Rx_Valid = rx_valid_reg;
  assign bus.SCLK     = sclk_reg;
  assign bus.MOSI     = mosi_reg;
  assign bus.CS_n     = cs_n_reg;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (CLK_DIV=4 and CLK_DIV=1) driven from a vector
// table and hand sequences; per-frame monitors summarise what appeared on the SPI pins.
module tb_spi_master_ctrl;
  localparam int W    = 8;
  localparam int NDUT = 2;

  typedef struct {
    int             lat;
    int             nrise;
    logic [W-1:0]   mosi_bits;
    logic [W-1:0]   rx;
    int             gap;
    int             bad_period;
    bit             mosi_low;
  } frame_t;

  typedef struct {
    int           dut;
    logic [W-1:0] tx;
    bit           loopb;
    logic [W-1:0] slave;
    logic [W-1:0] exp_rx;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W-1:0] tx_data    [NDUT];
  logic         tx_valid   [NDUT];
  logic         loop_en    [NDUT];
  logic [W-1:0] slave_word [NDUT];
  logic         cs_n_w     [NDUT];
  logic         sclk_w     [NDUT];
  logic         mosi_w     [NDUT];
  logic         tx_ready_w [NDUT];
  logic         rx_valid_w [NDUT];
  logic [W-1:0] rx_data_w  [NDUT];

  int total = 0;
  int bad   = 0;

  function automatic int div_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    localparam int DIV = (gi == 0) ? 4 : 1;

    spi_master_ctrl_if #(.Register_Width(W)) bus ();
    logic slave_bit;

    spi_master_ctrl #(.Register_Width(W), .CLK_DIV(DIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );

    int     edge_n = 0;
    int     acc_q[$];
    frame_t res_q[$];
    int     nrise = 0;
    int     nfall = 0;
    int     cs_hi = 1000;
    int     gap = 0;
    int     last_rise = -1;
    int     bad_period = 0;
    int     cs_sclk_viol = 0;
    logic [W-1:0] mosi_bits = '0;
    bit     mosi_low = 1'b0;
    logic   p_sclk = 1'b0;
    logic   p_cs = 1'b1;

    assign bus.Tx_Data     = tx_data[gi];
    assign bus.Tx_Valid    = tx_valid[gi];
    // Slave presents bit k after the k-th falling SCLK edge of the frame.
    assign slave_bit       = (nfall < W) ? slave_word[gi][W-1-nfall] : 1'b0;
    assign bus.MISO        = loop_en[gi] ? bus.MOSI : slave_bit;
    assign cs_n_w[gi]      = bus.CS_n;
    assign sclk_w[gi]      = bus.SCLK;
    assign mosi_w[gi]      = bus.MOSI;
    assign tx_ready_w[gi]  = bus.Tx_Ready;
    assign rx_valid_w[gi]  = bus.Rx_Valid;
    assign rx_data_w[gi]   = bus.Rx_Data;

    initial begin : acc_mon
      forever begin
        @(posedge clk);
        if (rst) acc_q.delete();
        else if (bus.Tx_Valid === 1'b1 && bus.Tx_Ready === 1'b1) acc_q.push_back(edge_n);
        edge_n = edge_n + 1;
      end
    end

    initial begin : pin_mon
      frame_t f;
      forever begin
        @(negedge clk);
        if (bus.CS_n !== p_cs && bus.SCLK === 1'b1) cs_sclk_viol++;
        if (p_cs === 1'b1 && bus.CS_n === 1'b0) begin
          gap = cs_hi; nrise = 0; nfall = 0; mosi_bits = '0;
          mosi_low = 1'b0; last_rise = -1; bad_period = 0;
        end
        if (bus.CS_n === 1'b1) cs_hi++;
        else begin
          cs_hi = 0;
          if (bus.MOSI !== 1'b1) mosi_low = 1'b1;
        end
        if (bus.SCLK === 1'b1 && p_sclk === 1'b0) begin
          mosi_bits = {mosi_bits[W-2:0], bus.MOSI};
          nrise++;
          if (last_rise >= 0 && (edge_n - 1 - last_rise) != 2 * DIV) bad_period++;
          last_rise = edge_n - 1;
        end
        if (bus.SCLK === 1'b0 && p_sclk === 1'b1) nfall++;
        if (bus.Rx_Valid === 1'b1) begin
          f.lat = -1;
          if (acc_q.size() > 0) f.lat = edge_n - 1 - acc_q.pop_front();
          f.nrise = nrise; f.mosi_bits = mosi_bits; f.rx = bus.Rx_Data;
          f.gap = gap; f.bad_period = bad_period; f.mosi_low = mosi_low;
          res_q.push_back(f);
        end
        p_sclk = bus.SCLK;
        p_cs   = bus.CS_n;
      end
    end
  end

  function automatic int res_cnt(input int d);
    return (d == 0) ? g_dut[0].res_q.size() : g_dut[1].res_q.size();
  endfunction

  task automatic pop_res(input int d, output frame_t f);
    if (d == 0) f = g_dut[0].res_q.pop_front();
    else        f = g_dut[1].res_q.pop_front();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send(input int d, input logic [W-1:0] w);
    int n = 0;
    @(negedge clk);
    while (tx_ready_w[d] !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    tx_data[d]  = w;
    tx_valid[d] = 1'b1;
    @(negedge clk);
    tx_valid[d] = 1'b0;
  endtask

  task automatic get_frame(input int d, input string nm, output frame_t f, output bit ok);
    int n = 0;
    f = '{default: 0};
    while (res_cnt(d) == 0 && n < 400) begin @(negedge clk); n++; end
    ok = (res_cnt(d) != 0);
    chk({nm, " arrived"}, 32'(ok), 32'd1);
    if (ok) pop_res(d, f);
  endtask

  task automatic check_frame(input int d, input string nm, input logic [W-1:0] tx,
                             input logic [W-1:0] exp_rx, output frame_t f);
    bit ok;
    get_frame(d, nm, f, ok);
    if (!ok) return;
    $display("frame %s dut=%0d tx=%02h rx=%02h lat=%0d rises=%0d mosi=%02h",
             nm, d, tx, f.rx, f.lat, f.nrise, f.mosi_bits);
    chk({nm, " rx_data"},   32'(f.rx),         32'(exp_rx));
    chk({nm, " latency"},   32'(f.lat),        32'((2 * W + 2) * div_of(d)));
    chk({nm, " rises"},     32'(f.nrise),      32'(W));
    chk({nm, " mosi bits"}, 32'(f.mosi_bits),  32'(tx));
    chk({nm, " sclk period"}, 32'(f.bad_period), 32'd0);
  endtask

  task automatic check_idle(input string nm);
    chk({nm, " cs_n"},     32'(cs_n_w[0]),     32'd1);
    chk({nm, " sclk"},     32'(sclk_w[0]),     32'd0);
    chk({nm, " tx_ready"}, 32'(tx_ready_w[0]), 32'd1);
    chk({nm, " rx_valid"}, 32'(rx_valid_w[0]), 32'd0);
    chk({nm, " rx_data"},  32'(rx_data_w[0]),  32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t   vt[$];
    frame_t f;
    int     n;
    int     rises;
    logic   prev;

    for (int d = 0; d < NDUT; d++) begin
      tx_data[d] = '0; tx_valid[d] = 1'b0; loop_en[d] = 1'b1; slave_word[d] = '0;
    end

    // Vector table: expected Rx is the sent word in loopback, else the slave's word.
    vt.push_back('{0, 8'hA5, 1'b1, 8'h00, 8'hA5});
    vt.push_back('{0, 8'hFF, 1'b0, 8'h3C, 8'h3C});
    vt.push_back('{1, 8'h5A, 1'b1, 8'h00, 8'h5A});
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v.dut    = int'($urandom_range(1, 0));
      v.tx     = W'($urandom);
      v.loopb  = 1'($urandom);
      v.slave  = W'($urandom);
      v.exp_rx = v.loopb ? v.tx : v.slave;
      vt.push_back(v);
    end

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle("reset");
    chk("reset mosi", 32'(mosi_w[0]), 32'd0);

    foreach (vt[i]) begin
      loop_en[vt[i].dut]    = vt[i].loopb;
      slave_word[vt[i].dut] = vt[i].slave;
      send(vt[i].dut, vt[i].tx);
      check_frame(vt[i].dut, $sformatf("vec%0d", i), vt[i].tx, vt[i].exp_rx, f);
      if (vt[i].tx == '1) chk($sformatf("vec%0d mosi all ones", i), 32'(f.mosi_low), 32'd0);
    end

    // Idle reset after a frame that leaves MOSI high and Rx_Data non-zero.
    loop_en[0] = 1'b1;
    send(0, 8'hFF);
    check_frame(0, "pre_reset", 8'hFF, 8'hFF, f);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle("idle reset");
    chk("idle reset mosi", 32'(mosi_w[0]), 32'd0);

    // Back-to-back with Tx_Valid held high and Tx_Data scrambled while busy.
    @(negedge clk);
    tx_data[0] = 8'h01; tx_valid[0] = 1'b1;
    @(negedge clk);
    n = 0;
    while (tx_ready_w[0] !== 1'b1 && n < 400) begin
      tx_data[0] = W'($urandom);
      @(negedge clk);
      n++;
    end
    tx_data[0] = 8'h80;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    check_frame(0, "b2b_first", 8'h01, 8'h01, f);
    for (int i = 0; i < 20; i++) begin
      tx_data[0] = W'($urandom);
      @(negedge clk);
    end
    check_frame(0, "b2b_second", 8'h80, 8'h80, f);
    chk("b2b cs_n high gap", 32'(f.gap), 32'd1);

    // Abort one cycle after the third rising SCLK edge.
    send(0, 8'hC3);
    n = 0; rises = 0; prev = sclk_w[0];
    while (rises < 3 && n < 400) begin
      @(negedge clk);
      if (sclk_w[0] === 1'b1 && prev === 1'b0) rises++;
      prev = sclk_w[0];
      n++;
    end
    chk("abort third rise seen", 32'(rises), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("abort");
    repeat (150) @(negedge clk);
    chk("abort no rx_valid", 32'(res_cnt(0)), 32'd0);

    for (int d = 0; d < NDUT; d++)
      chk($sformatf("dut%0d stray frames", d), 32'(res_cnt(d)), 32'd0);
    chk("dut0 sclk low at cs_n change", 32'(g_dut[0].cs_sclk_viol), 32'd0);
    chk("dut1 sclk low at cs_n change", 32'(g_dut[1].cs_sclk_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
